// File: rtl/rom_read_arbiter_if.sv
// Reader/ROM bundle for rom_read_arbiter: client requests, grants, responses and the ROM port.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_dout;

  modport master (
    output req, req_addr, rom_dout,
    input  gnt, rsp_valid, rsp_data, rom_addr
  );

  modport slave (
    input  req, req_addr, rom_dout,
    output gnt, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM among NUM_REQ readers.
// Optional grant/conflict statistics counters: define ROM_READ_ARBITER_STATS_EN.
module rom_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  rom_read_arbiter_if.slave bus
`ifdef ROM_READ_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_gnt_cnt,
  output logic [15:0]           stat_conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      idx;
  logic [PTR_W-1:0]      winner;
  logic                  any_gnt;
  logic [NUM_REQ-1:0]    gnt;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  tag_vld_p [ROM_LATENCY];
  logic [NUM_REQ-1:0]    tag_id_p  [ROM_LATENCY];

  // Scan starts at ptr and wraps; grant is suppressed while reset is held.
  always_comb begin
    idx      = '0;
    any_gnt  = 1'b0;
    winner   = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!any_gnt && bus.req[idx]) begin
        any_gnt = 1'b1;
        winner  = idx;
      end
    end
    any_gnt = any_gnt & ~rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign gnt          = any_gnt ? (NUM_REQ'(1) << winner) : '0;
  assign bus.gnt      = gnt;
  assign bus.rom_addr = any_gnt ? win_addr : addr_hold;
  assign bus.rsp_data = bus.rom_dout;
  assign bus.rsp_valid = tag_vld_p[ROM_LATENCY-1] ? tag_id_p[ROM_LATENCY-1] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      addr_hold <= '0;
    end else if (any_gnt) begin
      ptr       <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + PTR_W'(1);
      addr_hold <= win_addr;
    end
  end

  // Stage p0 captures the grant on the ROM address edge; last stage aligns with rom_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_id_p[i]  <= '0;
      end
    end else begin
      tag_vld_p[0] <= any_gnt;
      tag_id_p[0]  <= gnt;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
      end
    end
  end

`ifdef ROM_READ_ARBITER_STATS_EN
  logic [15:0] gnt_cnt [NUM_REQ];
  logic [15:0] conflict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && gnt_cnt[i] != 16'hFFFF) gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
      end
      if ($countones(bus.req) >= 2 && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_comb begin
    stat_gnt_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_gnt_cnt[i*16 +: 16] = gnt_cnt[i];
  end
  assign stat_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: ROM_LATENCY=1 and =2 instances against a queue-style reference model.
module tb_rom_read_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();
  rom_read_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(8), .ADDR_WIDTH(4)) bus2 ();

`ifdef ROM_READ_ARBITER_STATS_EN
  logic [N*16-1:0] st1_gnt, st2_gnt;
  logic [15:0]     st1_conf, st2_conf;
`endif

  rom_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .ADDR_WIDTH(4), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef ROM_READ_ARBITER_STATS_EN
    , .stat_gnt_cnt(st1_gnt), .stat_conflict_cnt(st1_conf)
`endif
  );

  rom_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .ADDR_WIDTH(4), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef ROM_READ_ARBITER_STATS_EN
    , .stat_gnt_cnt(st2_gnt), .stat_conflict_cnt(st2_conf)
`endif
  );

  // ROM contents and the one- and two-stage ROM read paths.
  logic [7:0] mem [16];
  logic [7:0] rom1_q, rom2_a, rom2_q;
  initial for (int i = 0; i < 16; i++) mem[i] = 8'((i * 37 + 11) ^ 8'h5A);
  always @(posedge clk) begin
    rom1_q <= mem[bus1.rom_addr];
    rom2_a <= mem[bus2.rom_addr];
    rom2_q <= rom2_a;
  end
  assign bus1.rom_dout = rom1_q;
  assign bus2.rom_dout = rom2_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: round-robin choice from the pointer, plus a history of granted edges.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] addr_of(input logic [N*4-1:0] a, input int w);
    return 4'((a >> (4 * w)) & 16'hF);
  endfunction

  int         m_ptr = 0;
  logic [3:0] m_hold = '0;
  logic       hv [2] = '{1'b0, 1'b0};
  int         hid [2] = '{0, 0};
  logic [3:0] ha [2] = '{4'h0, 4'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  <= 0;
      m_hold <= '0;
      hv[0]  <= 1'b0;
      hv[1]  <= 1'b0;
    end else begin
      if (pick(bus1.req, m_ptr) >= 0) begin
        m_ptr  <= (pick(bus1.req, m_ptr) + 1) % N;
        m_hold <= addr_of(bus1.req_addr, pick(bus1.req, m_ptr));
      end
      hv[0]  <= pick(bus1.req, m_ptr) >= 0;
      hid[0] <= pick(bus1.req, m_ptr);
      ha[0]  <= addr_of(bus1.req_addr, pick(bus1.req, m_ptr));
      hv[1]  <= hv[0];
      hid[1] <= hid[0];
      ha[1]  <= ha[0];
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", 64'(bus1.gnt), 64'h0);
      chk("rst_rsp_valid1", 64'(bus1.rsp_valid), 64'h0);
      chk("rst_rsp_valid2", 64'(bus2.rsp_valid), 64'h0);
      chk("rst_rom_addr", 64'(bus1.rom_addr), 64'h0);
    end else begin
      int w;
      logic [N-1:0] eg;
      logic [3:0]   ea;
      w  = pick(bus1.req, m_ptr);
      eg = (w < 0) ? '0 : N'(1) << w;
      ea = (w < 0) ? m_hold : addr_of(bus1.req_addr, w);
      chk("gnt1", 64'(bus1.gnt), 64'(eg));
      chk("gnt2", 64'(bus2.gnt), 64'(eg));
      chk("rom_addr1", 64'(bus1.rom_addr), 64'(ea));
      chk("rom_addr2", 64'(bus2.rom_addr), 64'(ea));
      chk("rsp_valid1", 64'(bus1.rsp_valid), hv[0] ? 64'(1) << hid[0] : 64'h0);
      chk("rsp_valid2", 64'(bus2.rsp_valid), hv[1] ? 64'(1) << hid[1] : 64'h0);
      if (hv[0]) chk("rsp_data1", 64'(bus1.rsp_data), 64'(mem[ha[0]]));
      if (hv[1]) chk("rsp_data2", 64'(bus2.rsp_data), 64'(mem[ha[1]]));
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic [N*4-1:0] a);
    bus1.req = r;  bus1.req_addr = a;
    bus2.req = r;  bus2.req_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0);
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    drive('0, '0);
    do_reset();

    // Single requester 2 at address 5.
    drive(4'b0100, 16'h0500);
    @(negedge clk);
    chk("single_gnt", 64'(bus1.gnt), 64'h4);
    chk("single_rom_addr", 64'(bus1.rom_addr), 64'h5);
    step();
    drive('0, '0);
    @(negedge clk);
    chk("single_rsp_valid1", 64'(bus1.rsp_valid), 64'h4);
    chk("single_rsp_data1", 64'(bus1.rsp_data), 64'(mem[5]));
    chk("single_rsp_valid2_early", 64'(bus2.rsp_valid), 64'h0);
    chk("single_hold_addr", 64'(bus1.rom_addr), 64'h5);
    step();
    @(negedge clk);
    chk("single_rsp_valid2", 64'(bus2.rsp_valid), 64'h4);
    chk("single_rsp_data2", 64'(bus2.rsp_data), 64'(mem[5]));
    chk("single_rsp_valid1_gone", 64'(bus1.rsp_valid), 64'h0);
    step();

    // Full contention from a fresh pointer.
    do_reset();
    drive(4'b1111, 16'h3C96);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("contend_gnt", 64'(bus1.gnt), 64'(1) << (i % 4));
      step();
    end

    // Pointer skips idle requesters 1 and 2.
    drive(4'b1001, 16'h7004);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wrap_gnt", 64'(bus1.gnt), (i % 2 == 1) ? 64'h8 : 64'h1);
      step();
    end

    // Sole requester streaming addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(4'b0010, 16'(i) << 4);
      @(negedge clk);
      chk("stream_gnt", 64'(bus1.gnt), 64'h2);
      if (i > 0) chk("stream_rsp_data", 64'(bus1.rsp_data), 64'(mem[i-1]));
      step();
    end
    drive('0, '0);
    @(negedge clk);
    chk("stream_last_data", 64'(bus1.rsp_data), 64'(mem[7]));
    step();

    // Reset while a response is outstanding.
    drive(4'b1000, 16'h9000);
    @(negedge clk);
    chk("midrst_gnt", 64'(bus1.gnt), 64'h8);
    step();
    rst = 1'b1;
    drive('0, '0);
    @(negedge clk);
    chk("midrst_rsp_valid1", 64'(bus1.rsp_valid), 64'h0);
    chk("midrst_rsp_valid2", 64'(bus2.rsp_valid), 64'h0);
    chk("midrst_rom_addr", 64'(bus1.rom_addr), 64'h0);
    step();
    rst = 1'b0;
    drive(4'b1010, 16'h2030);
    @(negedge clk);
    chk("postrst_gnt", 64'(bus1.gnt), 64'h2);
    step();
    @(negedge clk);
    chk("postrst_rsp2_discarded", 64'(bus2.rsp_valid), 64'h0);
    step();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        drive('0, '0);
        step();
        rst = 1'b0;
      end
      drive(N'($urandom_range(0, 15)), 16'($urandom));
      step();
    end

`ifdef ROM_READ_ARBITER_STATS_EN
    do_reset();
    drive(4'b0011, 16'h0021);
    repeat (8) step();
    drive('0, '0);
    @(negedge clk);
    chk("stat_gnt0", 64'(st2_gnt[15:0]), 64'd4);
    chk("stat_gnt1", 64'(st2_gnt[31:16]), 64'd4);
    chk("stat_gnt2", 64'(st2_gnt[47:32]), 64'd0);
    chk("stat_conflict", 64'(st2_conf), 64'd8);
    chk("stat_conflict_l1", 64'(st1_conf), 64'd8);
    step();
`endif

    drive('0, '0);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one synchronous-read `rom` instance between NUM_REQ independent readers.
- Each cycle, picks one requester by round-robin and drives its address to the ROM.
- Routes the returned word back to that requester, tagged with rsp_valid, after ROM_LATENCY cycles.
- Sits between the fetch/lookup clients and the `rom` (DATA_WIDTH=8, ADDR_WIDTH=4 by default).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 4, ROM address width.
- ROM_LATENCY, 1, clock edges from ROM address sample to valid rom_dout (1 or 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester read request; held with stable address until granted.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  output  NUM_REQ  one-hot grant, combinational; transfer occurs on the edge where req[i]&gnt[i].
- rsp_valid  output  NUM_REQ  one-hot, high for one cycle when rsp_data belongs to requester i.
- rsp_data  output  DATA_WIDTH  read data, shared by all requesters; equals rom_dout.
- rom_addr  output  ADDR_WIDTH  address to the ROM's addr input.
- rom_dout  input  DATA_WIDTH  ROM read data.

Behaviour:
- Reset: asserting rst clears all state immediately. Reset values:
  - gnt=0 (no req can be high-qualified).
  - rsp_valid=0.
  - rom_addr=0 (hold register).
  - rr pointer=0.
  - tag pipeline all-invalid.
- Reset mid-flight discards every outstanding response; no rsp_valid is issued for it after release.
- Arbitration is combinational each cycle:
  - Scan indices ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1, wrapping.
  - The first index with req high gets gnt.
  - At most one gnt bit is high. gnt=0 when req=0.
- Pointer update: on an edge with a grant to index k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds.
- rom_addr:
  - In a grant cycle, equals req_addr of the winner (combinational mux).
  - Otherwise, equals the last granted address (hold register updated on grant edges; 0 after reset).
- Tag pipeline:
  - A ROM_LATENCY-deep shift register of {valid, one-hot id}.
  - Loaded with {1, gnt} on a grant edge, else {0, 0}.
  - rsp_valid = last stage valid ? id : 0.
  - Response for a grant at edge E appears in the cycle after edge E+ROM_LATENCY-1. Example: ROM_LATENCY=1 gives rsp_valid high in the cycle right after the grant edge.
- Throughput: one grant per cycle; back-to-back grants with non-overlapping responses.
- The same requester may be granted on consecutive edges only if it is the sole requester.
- Requester protocol:
  - Keep req high and req_addr stable until the edge where gnt is seen.
  - Deasserting req without a grant is allowed (request withdrawn, no response).
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ cycles.

Optional Feature:
- Macro: ROM_READ_ARBITER_STATS_EN.
- When defined, adds outputs:
  - stat_gnt_cnt  NUM_REQ*16: per-requester grant count, saturating at 16'hFFFF.
  - stat_conflict_cnt  16: count of cycles with two or more req bits high, saturating.
- Both counters are cleared by rst.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: req[2]=1, addr 4'h5 for one cycle → gnt=4'b0100 that cycle, rom_addr=5; next cycle rsp_valid=4'b0100, rsp_data=ROM[5].
- Contention: req=4'b1111 held 8 cycles after reset → grants in order 0,1,2,3,0,1,2,3; each rsp_valid follows its grant by 1 cycle with the matching ROM word.
- Pointer wrap/skip: req=4'b1001 continuous → gnt alternates 0001, 1000; ptr never stalls on idle requesters 1 and 2.
- Sole requester streaming: req[1] held, addr incremented 0..7 each grant → 8 consecutive grants, rsp_data = ROM[0..7] in order, no gaps.
- Reset mid-flight: grant at edge E, assert rst before the response cycle → rsp_valid stays 0, rom_addr=0; after release, first grant goes to the lowest requesting index.
- ROM_LATENCY=2 with a 2-stage ROM model; with ROM_READ_ARBITER_STATS_EN defined, 8 cycles of req=4'b0011 → responses 2 cycles after each grant, stat_gnt_cnt[0]=stat_gnt_cnt[1]=4, stat_conflict_cnt=8.
